// File: rtl/lfsr_rand_stream.sv
// Fibonacci-LFSR random source with selectable width, multi-step decorrelation,
// runtime seed loading with a lock-up guard, and a valid/ready output stream.
module lfsr_rand_stream #(
    parameter int unsigned LFSR_W = 24,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned STEPS  = 1,
    parameter logic [31:0] SEED   = 32'h0012_3456
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  rand_num,
    output logic              rand_valid,
    input  logic              rand_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    // Tap masks for the supported maximal-length polynomials.
    localparam logic [31:0] TAP_ALL = (LFSR_W == 16) ? 32'h0000_D008 :
                                      (LFSR_W == 24) ? 32'h00E1_0000 :
                                                       32'h8020_0003;
    localparam logic [LFSR_W-1:0] TAPS   = TAP_ALL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_W = SEED[LFSR_W-1:0];

    if (!(LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
        $error("lfsr_rand_stream: LFSR_W must be 16, 24 or 32");
    end
    if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
        $error("lfsr_rand_stream: OUT_W must be in 1..LFSR_W");
    end
    if (STEPS < 1 || STEPS > LFSR_W) begin : g_bad_steps
        $error("lfsr_rand_stream: STEPS must be in 1..LFSR_W");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("lfsr_rand_stream: SEED low LFSR_W bits must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  cnt;
    logic [LFSR_W-1:0] lfsr_next_c;
    logic              last_step_c;

    assign lfsr_next_c = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    assign last_step_c = (cnt == CNT_W'(STEPS - 1));

    // Seed load overrides everything; a handshake in the same cycle is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lfsr       <= SEED_W;
            cnt        <= '0;
            rand_num   <= '0;
            rand_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (seed_load) begin
            state      <= IDLE;
            lfsr       <= (seed_in == '0) ? SEED_W : seed_in;
            cnt        <= '0;
            rand_num   <= '0;
            rand_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        lfsr <= lfsr_next_c;
                        if (last_step_c) begin
                            rand_num   <= lfsr_next_c[OUT_W-1:0];
                            rand_valid <= 1'b1;
                            cnt        <= '0;
                            busy       <= 1'b0;
                            state      <= VALID;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                VALID: begin
                    if (rand_valid && rand_ready) begin
                        rand_valid <= 1'b0;
                        if (enable) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    rand_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Directed bench for lfsr_rand_stream: several parameter sets driven from
// shared controls, checked against hand values and a bit-level reference step.
module tb_lfsr_rand_stream;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        seed_load;
    logic        rand_ready;
    logic [23:0] seed_in24;
    logic [15:0] seed_in16;
    logic [31:0] seed_in32;

    logic [11:0] num24;
    logic        vld24, busy24;
    logic [23:0] num4;
    logic        vld4, busy4;
    logic [11:0] num8;
    logic        vld8, busy8;
    logic [15:0] num16;
    logic        vld16, busy16;
    logic [31:0] num32;
    logic        vld32, busy32;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_rand_stream #(.LFSR_W(24), .OUT_W(12), .STEPS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in24), .rand_num(num24), .rand_valid(vld24),
        .rand_ready(rand_ready), .busy(busy24));

    lfsr_rand_stream #(.LFSR_W(24), .OUT_W(24), .STEPS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in24), .rand_num(num4), .rand_valid(vld4),
        .rand_ready(rand_ready), .busy(busy4));

    lfsr_rand_stream #(.LFSR_W(24), .OUT_W(12), .STEPS(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in24), .rand_num(num8), .rand_valid(vld8),
        .rand_ready(rand_ready), .busy(busy8));

    lfsr_rand_stream #(.LFSR_W(16), .OUT_W(16), .STEPS(15)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in16), .rand_num(num16), .rand_valid(vld16),
        .rand_ready(rand_ready), .busy(busy16));

    lfsr_rand_stream #(.LFSR_W(32), .OUT_W(32), .STEPS(1)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in32), .rand_num(num32), .rand_valid(vld32),
        .rand_ready(rand_ready), .busy(busy32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference single shift, written directly from the tap lists.
    function automatic logic [31:0] m_step(input int unsigned w, input logic [31:0] s);
        logic        fb;
        logic [31:0] mask;
        case (w)
            16:      fb = s[15] ^ s[14] ^ s[12] ^ s[3];
            24:      fb = s[23] ^ s[22] ^ s[21] ^ s[16];
            default: fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        endcase
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return ((s << 1) | 32'(fb)) & mask;
    endfunction

    function automatic logic [31:0] m_steps(input int unsigned w, input logic [31:0] s,
                                            input int unsigned n);
        logic [31:0] r = s;
        for (int k = 0; k < int'(n); k++) r = m_step(w, r);
        return r;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n    = 1'b0;
        enable     = 1'b0;
        rand_ready = 1'b0;
        seed_load  = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_rst(input logic en, input logic rdy);
        reset_n    = 1'b1;
        enable     = en;
        rand_ready = rdy;
    endtask

    initial begin
        logic [11:0] run_a [3];
        logic [11:0] run_b [3];
        logic [23:0] cap4;
        logic [31:0] m24, m32, m16;
        int          lat, got_n, c24, c32, c16;
        bit          found;

        reset_n = 1'b0; enable = 1'b0; rand_ready = 1'b0; seed_load = 1'b0;
        seed_in24 = '0; seed_in16 = '0; seed_in32 = '0;
        tick();
        tick();
        check_eq("rst_num",   32'(num24),  32'h0);
        check_eq("rst_valid", 32'(vld24),  32'h0);
        check_eq("rst_busy",  32'(busy24), 32'h0);

        // Free-running, ready held high: samples 0x8AC then 0x159.
        release_rst(1'b1, 1'b1);
        tick();
        check_eq("t1_c1_valid", 32'(vld24),  32'h0);
        check_eq("t1_c1_busy",  32'(busy24), 32'h1);
        tick();
        check_eq("t1_s0_valid", 32'(vld24), 32'h1);
        check_eq("t1_s0_num",   32'(num24), 32'h8AC);
        tick();
        check_eq("t1_gap_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t1_s1_valid", 32'(vld24), 32'h1);
        check_eq("t1_s1_num",   32'(num24), 32'h159);

        // Back-pressure: sample holds for 10 cycles, next arrives two cycles after ready rises.
        do_reset();
        release_rst(1'b1, 1'b0);
        tick();
        tick();
        check_eq("t2_s0_num", 32'(num24), 32'h8AC);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_hold_valid", 32'(vld24), 32'h1);
            check_eq("t2_hold_num",   32'(num24), 32'h8AC);
        end
        rand_ready = 1'b1;
        tick();
        check_eq("t2_acc_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t2_s1_valid", 32'(vld24), 32'h1);
        check_eq("t2_s1_num",   32'(num24), 32'h159);

        // STEPS=4 with a 3-cycle enable gap mid-SHIFT: valid moves from cycle 5 to 8.
        do_reset();
        release_rst(1'b1, 1'b1);
        found = 1'b0;
        lat   = 0;
        cap4  = '0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (vld4) begin
                found = 1'b1;
                lat   = i;
                cap4  = num4;
            end
            if (i == 3) check_eq("t3_pause_busy", 32'(busy4), 32'h1);
            if (i == 2) enable = 1'b0;
            if (i == 5) enable = 1'b1;
        end
        check_eq("t3_found",   32'(found), 32'h1);
        check_eq("t3_latency", 32'(lat),   32'd8);
        check_eq("t3_num",     32'(cap4),  m_steps(24, 32'h0012_3456, 4));

        // Zero seed load in VALID falls back to SEED; sequence restarts at 0x8AC.
        do_reset();
        release_rst(1'b1, 1'b0);
        tick();
        tick();
        check_eq("t4_pre_valid", 32'(vld24), 32'h1);
        seed_in24 = 24'h0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check_eq("t4_ld_valid", 32'(vld24),  32'h0);
        check_eq("t4_ld_num",   32'(num24),  32'h0);
        check_eq("t4_ld_busy",  32'(busy24), 32'h0);
        tick();
        check_eq("t4_c2_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t4_s0_valid", 32'(vld24), 32'h1);
        check_eq("t4_s0_num",   32'(num24), 32'h8AC);

        // Load 0xABCDEF coinciding with a handshake: one sample 0xBDF, no duplicate of 0x8AC.
        rand_ready = 1'b1;
        seed_in24  = 24'hABCDEF;
        seed_load  = 1'b1;
        tick();
        seed_load = 1'b0;
        check_eq("t5_ld_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t5_c2_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t5_s0_valid", 32'(vld24), 32'h1);
        check_eq("t5_s0_num",   32'(num24), 32'hBDF);
        check_eq("t5_s0_model", 32'(num24), m_step(24, 32'h00AB_CDEF) & 32'hFFF);
        tick();
        check_eq("t5_gap_valid", 32'(vld24), 32'h0);
        tick();
        check_eq("t5_s1_num", 32'(num24), m_steps(24, 32'h00AB_CDEF, 2) & 32'hFFF);

        // STEPS=8: reference run, then async reset mid-SHIFT, then identical rerun.
        do_reset();
        release_rst(1'b1, 1'b1);
        got_n = 0;
        for (int i = 0; i < 40 && got_n < 3; i++) begin
            tick();
            if (vld8) begin
                run_a[got_n] = num8;
                got_n++;
            end
        end
        check_eq("t6_a_count", 32'(got_n), 32'd3);
        check_eq("t6_a_s0", 32'(run_a[0]), m_steps(24, 32'h0012_3456, 8) & 32'hFFF);
        do_reset();
        release_rst(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_mid_busy", 32'(busy8), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_busy",  32'(busy8), 32'h0);
        check_eq("t6_async_valid", 32'(vld8),  32'h0);
        check_eq("t6_async_num",   32'(num8),  32'h0);
        tick();
        release_rst(1'b1, 1'b1);
        got_n = 0;
        for (int i = 0; i < 40 && got_n < 3; i++) begin
            tick();
            if (vld8) begin
                run_b[got_n] = num8;
                got_n++;
            end
        end
        check_eq("t6_b_count", 32'(got_n), 32'd3);
        for (int k = 0; k < 3; k++) check_eq("t6_rerun", 32'(run_b[k]), 32'(run_a[k]));

        // Long run against the reference: 10k samples at 24/32 bits, full 16-bit period.
        do_reset();
        release_rst(1'b1, 1'b1);
        tick();
        check_eq("t7_busy16", 32'(busy16), 32'h1);
        check_eq("t7_busy32", 32'(busy32), 32'h1);
        m24 = 32'h0012_3456;
        m32 = 32'h0012_3456;
        m16 = 32'h0000_3456;
        c24 = 0;
        c32 = 0;
        c16 = 0;
        for (int i = 0; i < 72000 && !(c24 >= 10000 && c32 >= 10000 && c16 >= 4369); i++) begin
            tick();
            if (vld24 && c24 < 10000) begin
                m24 = m_step(24, m24);
                check_eq("t7_num24", 32'(num24), m24 & 32'hFFF);
                c24++;
            end
            if (vld32 && c32 < 10000) begin
                m32 = m_step(32, m32);
                check_eq("t7_num32", num32, m32);
                check_eq("t7_zero32", 32'(num32 == 32'h0), 32'h0);
                c32++;
            end
            if (vld16 && c16 < 4369) begin
                m16 = m_steps(16, m16, 15);
                c16++;
                check_eq("t7_num16", 32'(num16), m16);
                if (c16 < 4369)
                    check_eq("t7_early_wrap16", 32'(num16 == 16'h3456), 32'h0);
                else
                    check_eq("t7_period16", 32'(num16), 32'h3456);
            end
        end
        check_eq("t7_count24", 32'(c24), 32'd10000);
        check_eq("t7_count32", 32'(c32), 32'd10000);
        check_eq("t7_count16", 32'(c16), 32'd4369);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
